// File: rtl/qpsk_sync_pkg.sv
// Shared constants for the QPSK frame synchroniser: sync-state encodings,
// hard-symbol codes and default frame geometry.
package qpsk_sync_pkg;

   localparam logic [1:0] SEARCH = 2'b00;
   localparam logic [1:0] VERIFY = 2'b01;
   localparam logic [1:0] LOCKED = 2'b10;

   localparam logic [1:0] SYM0 = 2'b01;
   localparam logic [1:0] SYM1 = 2'b11;

   localparam int                        DEF_FRAME_LEN   = 1027;
   localparam int                        DEF_BARKER_LEN  = 4;
   localparam logic [DEF_BARKER_LEN-1:0] DEF_BARKER_CODE = 4'b1101;

   // 3-bit saturating increment used by the hit and miss counters
   function automatic logic [2:0] sat_inc3(input logic [2:0] v);
      return (v == 3'b111) ? v : v + 3'd1;
   endfunction

endpackage

// File: rtl/barker_frame_sync_if.sv
// Symbol-side bus of the frame synchroniser: demodulator symbols in,
// aligned symbols and sync status out to the BER checker.
interface barker_frame_sync_if;
   logic        sym_en;
   logic [1:0]  bit_rev;
   logic [1:0]  enable;
   logic [11:0] count;
   logic [1:0]  bit_rev_delay;
   logic [1:0]  sync_state;
   logic        frame_start;
   logic        lock_lost;

   modport master (
      output sym_en, bit_rev,
      input  enable, count, bit_rev_delay, sync_state, frame_start, lock_lost
   );

   modport slave (
      input  sym_en, bit_rev,
      output enable, count, bit_rev_delay, sync_state, frame_start, lock_lost
   );
endinterface

// File: rtl/barker_correlator.sv
// Sliding Barker window: keeps the previous BARKER_LEN-1 symbols and scores
// them together with the current symbol against the preamble code.
module barker_correlator
   import qpsk_sync_pkg::*;
#(
   parameter int                    BARKER_LEN  = DEF_BARKER_LEN,
   parameter logic [BARKER_LEN-1:0] BARKER_CODE = DEF_BARKER_CODE,
   parameter int                    MAX_ERR     = 0
)(
   input  logic       clk_fs,
   input  logic       rst_n,
   input  logic       sym_en,
   input  logic [1:0] bit_rev,
   output logic       hit
);

   localparam int ERR_W = $clog2(BARKER_LEN + 1);

   // index 0 is the newest symbol, so it lines up with BARKER_CODE[0]
   logic [BARKER_LEN-2:0][1:0] hist_q;
   logic [BARKER_LEN-1:0][1:0] win;
   logic [ERR_W-1:0]           err;

   // post-shift window: current symbol plus stored history
   always_comb begin
      win[0] = bit_rev;
      for (int k = 1; k < BARKER_LEN; k++) begin
         win[k] = hist_q[k-1];
      end
   end

   // count positions that are invalid or decode to the wrong bit
   always_comb begin
      err = '0;
      for (int k = 0; k < BARKER_LEN; k++) begin
         if (win[k] != (BARKER_CODE[k] ? SYM1 : SYM0)) begin
            err = err + ERR_W'(1);
         end
      end
   end

   assign hit = (err <= ERR_W'(MAX_ERR));

   // shift history on each symbol strobe; cleared history reads as invalid
   always_ff @(posedge clk_fs or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= '0;
      end else if (sym_en) begin
         hist_q <= win[BARKER_LEN-2:0];
      end
   end

endmodule

// File: rtl/barker_frame_sync.sv
// Barker preamble frame synchroniser feeding the QPSK BER checker.
//
// state  | meaning
// SEARCH | hunting for the preamble at any position; enable low
// VERIFY | preamble seen once, checking it recurs at each frame wrap
// LOCKED | frame alignment confirmed; enable high, tracking misses
module barker_frame_sync
   import qpsk_sync_pkg::*;
#(
   parameter int                    BARKER_LEN  = DEF_BARKER_LEN,
   parameter logic [BARKER_LEN-1:0] BARKER_CODE = DEF_BARKER_CODE,
   parameter int                    FRAME_LEN   = DEF_FRAME_LEN,
   parameter int                    MAX_ERR     = 0,
   parameter int                    CONFIRM_N   = 2,
   parameter int                    MISS_N      = 3
)(
   input  logic                clk_fs,
   input  logic                rst_n,
   barker_frame_sync_if.slave  bus
);

   localparam logic [11:0] LAST_CNT  = 12'(FRAME_LEN - 1);
   localparam logic [2:0]  CONFIRM_C = 3'(CONFIRM_N);
   localparam logic [2:0]  MISS_C    = 3'(MISS_N);

   logic        hit;
   logic        wrap;
   logic [1:0]  state_q, state_nxt;
   logic [11:0] count_q, count_nxt;
   logic [2:0]  hit_cnt_q, hit_cnt_nxt;
   logic [2:0]  miss_cnt_q, miss_cnt_nxt;
   logic        lost_nxt;
   logic [1:0]  enable_q;
   logic [1:0]  bit_rev_delay_q;
   logic        frame_start_q;
   logic        lock_lost_q;

   barker_correlator #(
      .BARKER_LEN  (BARKER_LEN),
      .BARKER_CODE (BARKER_CODE),
      .MAX_ERR     (MAX_ERR)
   ) u_corr (
      .clk_fs  (clk_fs),
      .rst_n   (rst_n),
      .sym_en  (bus.sym_en),
      .bit_rev (bus.bit_rev),
      .hit     (hit)
   );

   assign wrap = (count_q == LAST_CNT);

   // next state, counters and position; only committed on a symbol strobe
   always_comb begin
      state_nxt    = state_q;
      hit_cnt_nxt  = hit_cnt_q;
      miss_cnt_nxt = miss_cnt_q;
      lost_nxt     = 1'b0;
      count_nxt    = wrap ? 12'd0 : count_q + 12'd1;
      case (state_q)
         SEARCH: begin
            // a hit realigns the frame even if it lands on a wrap
            if (hit) begin
               state_nxt   = VERIFY;
               count_nxt   = 12'd0;
               hit_cnt_nxt = 3'd0;
            end
         end
         VERIFY: begin
            if (wrap) begin
               if (hit) begin
                  hit_cnt_nxt = sat_inc3(hit_cnt_q);
                  if (hit_cnt_nxt >= CONFIRM_C) begin
                     state_nxt    = LOCKED;
                     miss_cnt_nxt = 3'd0;
                  end
               end else begin
                  state_nxt = SEARCH;
               end
            end
         end
         LOCKED: begin
            if (wrap) begin
               if (hit) begin
                  miss_cnt_nxt = 3'd0;
               end else begin
                  miss_cnt_nxt = sat_inc3(miss_cnt_q);
                  if (miss_cnt_nxt >= MISS_C) begin
                     state_nxt = SEARCH;
                     lost_nxt  = 1'b1;
                  end
               end
            end
         end
         default: state_nxt = SEARCH;
      endcase
   end

   // state and output registers; pulses last one clk_fs cycle
   always_ff @(posedge clk_fs or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= SEARCH;
         count_q         <= 12'd0;
         hit_cnt_q       <= 3'd0;
         miss_cnt_q      <= 3'd0;
         enable_q        <= 2'b00;
         bit_rev_delay_q <= SYM0;
         frame_start_q   <= 1'b0;
         lock_lost_q     <= 1'b0;
      end else begin
         frame_start_q <= 1'b0;
         lock_lost_q   <= 1'b0;
         if (bus.sym_en) begin
            state_q         <= state_nxt;
            count_q         <= count_nxt;
            hit_cnt_q       <= hit_cnt_nxt;
            miss_cnt_q      <= miss_cnt_nxt;
            bit_rev_delay_q <= bus.bit_rev;
            enable_q        <= (state_nxt == LOCKED) ? 2'b01 : 2'b00;
            frame_start_q   <= (count_nxt == 12'd0) && (state_nxt != SEARCH);
            lock_lost_q     <= lost_nxt;
         end
      end
   end

   assign bus.enable        = enable_q;
   assign bus.count         = count_q;
   assign bus.bit_rev_delay = bit_rev_delay_q;
   assign bus.sync_state    = state_q;
   assign bus.frame_start   = frame_start_q;
   assign bus.lock_lost     = lock_lost_q;

endmodule

// File: tb/tb_barker_frame_sync.sv
// Directed bench for barker_frame_sync: two instances (MAX_ERR 0 and 1)
// share stimulus; expected values are hand-derived frame positions.
module tb_barker_frame_sync;

   localparam logic [7:0] GOOD_PRE = 8'b11_11_01_11;
   localparam logic [7:0] BAD_PRE  = 8'b11_11_01_01;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sym_en = 1'b0;
   logic [1:0] bit_rev = 2'b01;

   int n_cmp = 0;
   int n_err = 0;

   logic pay [0:1022];

   logic [1:0]  s_state, s_en, s_brd, d1_state, d1_brd;
   logic [11:0] s_count, d1_count;
   logic        s_fs, s_ll;
   logic        en_any;
   int          ll_cnt;

   barker_frame_sync_if bus0 ();
   barker_frame_sync_if bus1 ();

   assign bus0.sym_en  = sym_en;
   assign bus0.bit_rev = bit_rev;
   assign bus1.sym_en  = sym_en;
   assign bus1.bit_rev = bit_rev;

   barker_frame_sync #(.MAX_ERR(0)) dut0 (.clk_fs(clk), .rst_n(rst_n), .bus(bus0));
   barker_frame_sync #(.MAX_ERR(1)) dut1 (.clk_fs(clk), .rst_n(rst_n), .bus(bus1));

   always #50 clk = ~clk;

   function automatic logic [1:0] psym(input int i);
      return pay[i] ? 2'b11 : 2'b01;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // one strobe cycle then one idle cycle; snapshot outputs just after the strobe edge
   task automatic send_sym(input logic [1:0] s);
      sym_en  = 1'b1;
      bit_rev = s;
      @(posedge clk);
      #1;
      s_state = bus0.sync_state; s_count = bus0.count; s_en = bus0.enable;
      s_brd = bus0.bit_rev_delay; s_fs = bus0.frame_start; s_ll = bus0.lock_lost;
      d1_state = bus1.sync_state; d1_count = bus1.count; d1_brd = bus1.bit_rev_delay;
      if (bus0.enable != 2'b00) en_any = 1'b1;
      if (bus0.lock_lost) ll_cnt++;
      sym_en = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic send_pre(input logic [7:0] p);
      for (int k = 3; k >= 0; k--) send_sym(p[2*k +: 2]);
   endtask

   task automatic send_payload();
      for (int i = 0; i < 1023; i++) send_sym(psym(i));
   endtask

   task automatic acquire();
      repeat (3) send_sym(2'b01);
      send_pre(GOOD_PRE);
      send_payload();
      send_pre(GOOD_PRE);
      send_payload();
      send_pre(GOOD_PRE);
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (bus0.enable !== 2'b00) begin n_err++; $display("FAIL reset_enable: got %b want 00", bus0.enable); end
      n_cmp++; if (bus0.count !== 12'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus0.count); end
      n_cmp++; if (bus0.bit_rev_delay !== 2'b01) begin n_err++; $display("FAIL reset_brd: got %b want 01", bus0.bit_rev_delay); end
      n_cmp++; if (bus0.sync_state !== 2'b00) begin n_err++; $display("FAIL reset_state: got %b want 00", bus0.sync_state); end
      n_cmp++; if (bus0.frame_start !== 1'b0) begin n_err++; $display("FAIL reset_fs: got %b want 0", bus0.frame_start); end
      n_cmp++; if (bus0.lock_lost !== 1'b0) begin n_err++; $display("FAIL reset_ll: got %b want 0", bus0.lock_lost); end
   endtask

   task automatic test_acquisition();
      do_reset();
      repeat (3) send_sym(2'b01);
      n_cmp++; if (s_count !== 12'd3) begin n_err++; $display("FAIL acq_search_count: got %0d want 3", s_count); end
      send_pre(GOOD_PRE);
      n_cmp++; if (s_state !== 2'b01) begin n_err++; $display("FAIL acq_verify: got %b want 01", s_state); end
      n_cmp++; if (s_count !== 12'd0) begin n_err++; $display("FAIL acq_count0: got %0d want 0", s_count); end
      n_cmp++; if (s_fs !== 1'b1) begin n_err++; $display("FAIL acq_fs_first: got %b want 1", s_fs); end
      send_payload();
      n_cmp++; if (s_count !== 12'd1023) begin n_err++; $display("FAIL acq_count1023: got %0d want 1023", s_count); end
      n_cmp++; if (s_fs !== 1'b0) begin n_err++; $display("FAIL acq_fs_mid: got %b want 0", s_fs); end
      send_sym(2'b11); send_sym(2'b11); send_sym(2'b01);
      n_cmp++; if (s_count !== 12'd1026) begin n_err++; $display("FAIL acq_count1026: got %0d want 1026", s_count); end
      send_sym(2'b11);
      n_cmp++; if (s_count !== 12'd0) begin n_err++; $display("FAIL acq_wrap1_count: got %0d want 0", s_count); end
      n_cmp++; if (s_state !== 2'b01) begin n_err++; $display("FAIL acq_wrap1_state: got %b want 01", s_state); end
      n_cmp++; if (s_fs !== 1'b1) begin n_err++; $display("FAIL acq_wrap1_fs: got %b want 1", s_fs); end
      send_payload();
      send_sym(2'b11); send_sym(2'b11); send_sym(2'b01);
      n_cmp++; if (s_en !== 2'b00) begin n_err++; $display("FAIL acq_en_prelock: got %b want 00", s_en); end
      send_sym(2'b11);
      n_cmp++; if (s_state !== 2'b10) begin n_err++; $display("FAIL acq_locked: got %b want 10", s_state); end
      n_cmp++; if (s_en !== 2'b01) begin n_err++; $display("FAIL acq_enable: got %b want 01", s_en); end
      n_cmp++; if (s_count !== 12'd0) begin n_err++; $display("FAIL acq_lock_count: got %0d want 0", s_count); end
      n_cmp++; if (s_fs !== 1'b1) begin n_err++; $display("FAIL acq_wrap2_fs: got %b want 1", s_fs); end
      send_sym(psym(0));
      n_cmp++; if (s_fs !== 1'b0) begin n_err++; $display("FAIL acq_fs_oneshot: got %b want 0", s_fs); end
      for (int i = 1; i < 1023; i++) send_sym(psym(i));
      send_pre(GOOD_PRE);
   endtask

   // entered LOCKED with count=0
   task automatic test_alignment();
      for (int i = 0; i < 1023; i++) begin
         send_sym(psym(i));
         if (i + 1 == 1 || i + 1 == 512 || i + 1 == 1023) begin
            n_cmp++; if (s_count !== 12'(i + 1)) begin n_err++; $display("FAIL align_count_%0d: got %0d want %0d", i + 1, s_count, i + 1); end
            n_cmp++; if (s_brd !== psym(i)) begin n_err++; $display("FAIL align_brd_%0d: got %b want %b", i + 1, s_brd, psym(i)); end
            n_cmp++; if (s_en !== 2'b01) begin n_err++; $display("FAIL align_en_%0d: got %b want 01", i + 1, s_en); end
         end
      end
      send_pre(GOOD_PRE);
      n_cmp++; if (s_state !== 2'b10) begin n_err++; $display("FAIL align_still_locked: got %b want 10", s_state); end
   endtask

   // entered LOCKED with count=0
   task automatic test_lock_loss();
      logic [7:0] seq [0:4];
      seq[0] = BAD_PRE; seq[1] = BAD_PRE; seq[2] = GOOD_PRE; seq[3] = BAD_PRE; seq[4] = BAD_PRE;
      ll_cnt = 0;
      for (int f = 0; f < 5; f++) begin
         send_payload();
         send_pre(seq[f]);
         n_cmp++; if (s_state !== 2'b10) begin n_err++; $display("FAIL loss_hold_state_f%0d: got %b want 10", f, s_state); end
         n_cmp++; if (s_fs !== 1'b1) begin n_err++; $display("FAIL loss_hold_fs_f%0d: got %b want 1", f, s_fs); end
      end
      send_payload();
      send_pre(BAD_PRE);
      n_cmp++; if (s_state !== 2'b00) begin n_err++; $display("FAIL loss_state: got %b want 00", s_state); end
      n_cmp++; if (s_en !== 2'b00) begin n_err++; $display("FAIL loss_enable: got %b want 00", s_en); end
      n_cmp++; if (s_ll !== 1'b1) begin n_err++; $display("FAIL loss_pulse: got %b want 1", s_ll); end
      n_cmp++; if (s_fs !== 1'b0) begin n_err++; $display("FAIL loss_fs: got %b want 0", s_fs); end
      send_sym(2'b01);
      n_cmp++; if (s_ll !== 1'b0) begin n_err++; $display("FAIL loss_pulse_clear: got %b want 0", s_ll); end
      n_cmp++; if (ll_cnt !== 1) begin n_err++; $display("FAIL loss_pulse_count: got %0d want 1", ll_cnt); end
   endtask

   task automatic test_false_hit();
      do_reset();
      en_any = 1'b0;
      repeat (3) send_sym(2'b01);
      send_pre(GOOD_PRE);
      n_cmp++; if (s_state !== 2'b01) begin n_err++; $display("FAIL false_verify: got %b want 01", s_state); end
      send_payload();
      repeat (3) send_sym(2'b01);
      n_cmp++; if (s_state !== 2'b01) begin n_err++; $display("FAIL false_prewrap: got %b want 01", s_state); end
      send_sym(2'b01);
      n_cmp++; if (s_state !== 2'b00) begin n_err++; $display("FAIL false_search: got %b want 00", s_state); end
      n_cmp++; if (s_fs !== 1'b0) begin n_err++; $display("FAIL false_fs: got %b want 0", s_fs); end
      n_cmp++; if (s_count !== 12'd0) begin n_err++; $display("FAIL false_count: got %0d want 0", s_count); end
      n_cmp++; if (en_any !== 1'b0) begin n_err++; $display("FAIL false_enable_seen: got %b want 0", en_any); end
   endtask

   task automatic test_wrap_hit();
      do_reset();
      repeat (1027) send_sym(2'b01);
      n_cmp++; if (s_count !== 12'd0) begin n_err++; $display("FAIL wrap_search_count: got %0d want 0", s_count); end
      n_cmp++; if (s_fs !== 1'b0) begin n_err++; $display("FAIL wrap_search_fs: got %b want 0", s_fs); end
      repeat (1023) send_sym(2'b01);
      send_sym(2'b11); send_sym(2'b11); send_sym(2'b01);
      n_cmp++; if (s_count !== 12'd1026) begin n_err++; $display("FAIL wrap_pre_count: got %0d want 1026", s_count); end
      n_cmp++; if (s_state !== 2'b00) begin n_err++; $display("FAIL wrap_pre_state: got %b want 00", s_state); end
      send_sym(2'b11);
      n_cmp++; if (s_count !== 12'd0) begin n_err++; $display("FAIL wrap_hit_count: got %0d want 0", s_count); end
      n_cmp++; if (s_state !== 2'b01) begin n_err++; $display("FAIL wrap_hit_state: got %b want 01", s_state); end
      n_cmp++; if (s_fs !== 1'b1) begin n_err++; $display("FAIL wrap_hit_fs: got %b want 1", s_fs); end
   endtask

   task automatic test_invalid();
      do_reset();
      repeat (3) send_sym(2'b01);
      send_sym(2'b11);
      send_sym(2'b10);
      n_cmp++; if (s_brd !== 2'b10) begin n_err++; $display("FAIL inv_brd0: got %b want 10", s_brd); end
      n_cmp++; if (d1_brd !== 2'b10) begin n_err++; $display("FAIL inv_brd1: got %b want 10", d1_brd); end
      send_sym(2'b01);
      send_sym(2'b11);
      n_cmp++; if (s_state !== 2'b00) begin n_err++; $display("FAIL inv_strict_miss: got %b want 00", s_state); end
      n_cmp++; if (d1_state !== 2'b01) begin n_err++; $display("FAIL inv_tolerant_hit: got %b want 01", d1_state); end
      n_cmp++; if (d1_count !== 12'd0) begin n_err++; $display("FAIL inv_tolerant_count: got %0d want 0", d1_count); end
   endtask

   task automatic test_reset_mid_locked();
      do_reset();
      acquire();
      for (int i = 0; i < 500; i++) send_sym(psym(i));
      n_cmp++; if (s_count !== 12'd500 || s_state !== 2'b10) begin n_err++; $display("FAIL mid_precond: got count %0d state %b want 500/10", s_count, s_state); end
      ll_cnt = 0;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (bus0.enable !== 2'b00) begin n_err++; $display("FAIL mid_enable: got %b want 00", bus0.enable); end
      n_cmp++; if (bus0.count !== 12'd0) begin n_err++; $display("FAIL mid_count: got %0d want 0", bus0.count); end
      n_cmp++; if (bus0.bit_rev_delay !== 2'b01) begin n_err++; $display("FAIL mid_brd: got %b want 01", bus0.bit_rev_delay); end
      n_cmp++; if (bus0.sync_state !== 2'b00) begin n_err++; $display("FAIL mid_state: got %b want 00", bus0.sync_state); end
      #20 rst_n = 1'b1;
      @(posedge clk);
      #1;
      repeat (3) send_sym(2'b01);
      n_cmp++; if (s_state !== 2'b00) begin n_err++; $display("FAIL mid_after_state: got %b want 00", s_state); end
      n_cmp++; if (ll_cnt !== 0) begin n_err++; $display("FAIL mid_no_pulse: got %0d want 0", ll_cnt); end
   endtask

   initial begin
      logic [9:0] lfsr;
      lfsr = 10'h001;
      for (int i = 0; i < 1023; i++) begin
         pay[i] = lfsr[0];
         lfsr = {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      end
      en_any = 1'b0;
      ll_cnt = 0;
      test_reset();
      test_acquisition();
      test_alignment();
      test_lock_loss();
      test_false_hit();
      test_wrap_hit();
      test_invalid();
      test_reset_mid_locked();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/barker_frame_sync.md
Name: barker_frame_sync

Overview:
- Frame synchroniser that sits directly upstream of the QPSK BER checker.
- Takes hard-decided 2-bit symbols from the demodulator and searches for the Barker preamble that opens each 1027-symbol frame.
- Confirms lock over several frames, then drives the checker's enable, the frame position count and the aligned received symbol bit_rev_delay.
- Detects loss of lock and returns to search.

Parameters:
- BARKER_LEN, 4: preamble length in symbols.
- BARKER_CODE, 4'b1101: preamble bit pattern; MSB is the first symbol received.
- FRAME_LEN, 1027: symbols per frame (preamble plus 1023-symbol m-sequence payload).
- MAX_ERR, 0: maximum mismatched preamble positions still accepted as a hit.
- CONFIRM_N, 2: consecutive expected-position hits needed to go from VERIFY to LOCKED.
- MISS_N, 3: consecutive expected-position misses needed to drop from LOCKED to SEARCH.

Ports:
- clk_fs  in  1  symbol-domain clock, 10 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- sym_en  in  1  one-cycle symbol strobe; all state advances only on sym_en=1.
- bit_rev  in  2  hard symbol: 2'b01 = bit 0, 2'b11 = bit 1; 2'b00 and 2'b10 are invalid.
- enable  out  2  2'b01 while LOCKED, else 2'b00.
- count  out  12  frame position, 0..FRAME_LEN-1.
- bit_rev_delay  out  2  received symbol aligned with count.
- sync_state  out  2  00 SEARCH, 01 VERIFY, 10 LOCKED.
- frame_start  out  1  one-cycle pulse on a strobe where count loads 0 while in VERIFY or LOCKED.
- lock_lost  out  1  one-cycle pulse on the LOCKED->SEARCH transition.

Behaviour:
- Reset (asynchronous assert, release on the next clk_fs edge):
  - enable=0, count=0, bit_rev_delay=2'b01, sync_state=SEARCH, frame_start=0, lock_lost=0.
  - Shift registers, hit counter and miss counter all cleared.
  - Reset asserted mid-frame aborts immediately; no pulse is emitted.
- Correlation window:
  - On each sym_en, the window holds the last BARKER_LEN symbols, including the current one.
  - Per-position mismatch: decoded bit (bit_rev[1]) differs from BARKER_CODE, or the symbol is invalid.
  - hit = (mismatch count <= MAX_ERR). It is evaluated combinationally on the post-shift window in the same strobe cycle.
- Count and data:
  - Every sym_en: bit_rev_delay <= bit_rev, and count <= (count==FRAME_LEN-1) ? 0 : count+1.
  - Exception: a SEARCH hit forces count <= 0.
  - Alignment: count=0 is the last preamble symbol, counts 1..1023 are the payload, and counts 1024..1026 are the first three preamble symbols of the next frame.
  - count and bit_rev_delay update on the same edge; latency from bit_rev to bit_rev_delay is 1 strobe.
  - While sync_state=SEARCH, count free-runs and its value is don't-care downstream, since enable=0.
- State machine, evaluated on sym_en only:
  - SEARCH, on hit: go to VERIFY, count<=0, hit counter<=0.
  - VERIFY, at the wrap strobe (count==FRAME_LEN-1):
    - hit: increment the hit counter; when it reaches CONFIRM_N, go to LOCKED.
    - miss: go to SEARCH.
  - VERIFY, hits at any other position are ignored.
  - LOCKED, at the wrap strobe:
    - hit: miss counter<=0.
    - miss: increment the miss counter; at MISS_N go to SEARCH and pulse lock_lost.
  - In LOCKED, count continues wrapping regardless of misses until lock is lost.
  - Entering LOCKED: enable=2'b01 from the edge that writes LOCKED, so the first enabled count value is 0.
  - Leaving LOCKED: enable=0 on the same edge.
- frame_start: asserted for one clk_fs cycle after each edge where count loads 0 while in VERIFY or LOCKED, including the SEARCH->VERIFY load. Never asserted in SEARCH.
- Simultaneous events:
  - A SEARCH hit on the same strobe as the count wrap: the hit wins and count=0.
  - sym_en held high on consecutive cycles is legal; each cycle is a symbol.
  - Invalid symbols propagate unchanged to bit_rev_delay.
- Widths: mismatch counter is $clog2(BARKER_LEN+1) bits; hit and miss counters are saturating, 3 bits.

Decomposition:
- Package qpsk_sync_pkg holds:
  - state encodings SEARCH/VERIFY/LOCKED;
  - symbol constants SYM0=2'b01 and SYM1=2'b11;
  - defaults FRAME_LEN=1027, BARKER_LEN=4 and BARKER_CODE=4'b1101.
- One sub-module, barker_correlator: window shift register plus mismatch count, outputs hit.
- The FSM, counters and output registers stay in the top level.

Test Plan:
- Reset mid-LOCKED: assert rst_n=0 at count=500 -> all outputs at reset values within the same cycle; after release, state is SEARCH.
- Clean acquisition: stream ideal frames (1101 + 1023-bit m-sequence, sym_en every 2nd clock) starting at a random offset.
  - The hit at the first preamble end sets count=0 and VERIFY.
  - LOCKED is reached at the 2nd subsequent wrap.
  - enable=2'b01 with count=0 on the same edge.
  - count reaches 1026 then wraps to 0, with frame_start pulsing each wrap.
- False hit: inject 1101 inside the payload while in SEARCH -> VERIFY; the pattern is absent at the next wrap -> SEARCH, and enable stays 0 throughout.
- Lock loss: once LOCKED, corrupt 3 consecutive preambles -> lock_lost pulses once at the 3rd wrap and enable=0. Corrupting only 2 and then sending a clean preamble keeps LOCKED and clears the miss counter.
- Invalid symbols: a preamble containing 2'b10 with MAX_ERR=0 -> miss. With MAX_ERR=1 -> hit, and bit_rev_delay carries 2'b10 unchanged.
- Alignment: with LOCKED and payload bit i known, check that at count=i the value bit_rev_delay equals the symbol sent as payload bit i, for i=1, 512 and 1023.
